// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, boot/run/fault sequencing, redirect and stall handling.
// Optional direct-mapped BTB is compiled in when FETCH_BTB_EN is defined.
module fetch_stage #(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0,
    parameter int                       BTB_ENTRIES   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stallf,
    input  logic                     pcsrce,
    input  logic [ADDRESS_WIDTH-1:0] pctargete,
    input  logic                     btb_upd,
    input  logic [ADDRESS_WIDTH-1:0] btb_pc,
    input  logic [ADDRESS_WIDTH-1:0] btb_target,
    output logic [ADDRESS_WIDTH-1:0] pcf,
    output logic [ADDRESS_WIDTH-1:0] pcplus4f,
    output logic                     validf,
    output logic                     predtakenf,
    output logic                     faultf
);

    typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;

    state_t                   state, state_next;
    logic [ADDRESS_WIDTH-1:0] pc_next;
    logic                     hit;
    logic [ADDRESS_WIDTH-1:0] hit_target;

    assign pcplus4f = pcf + ADDRESS_WIDTH'(4);

`ifdef FETCH_BTB_EN
    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = ADDRESS_WIDTH - IDX_W - 2;

    logic [BTB_ENTRIES-1:0]   btb_valid;
    logic [TAG_W-1:0]         btb_tag [BTB_ENTRIES];
    logic [ADDRESS_WIDTH-1:0] btb_tgt [BTB_ENTRIES];
    logic [IDX_W-1:0]         rd_idx, wr_idx;
    logic                     wr_en;
    logic                     unused_btb_bits;

    assign rd_idx     = pcf[IDX_W+1:2];
    assign wr_idx     = btb_pc[IDX_W+1:2];
    // misaligned targets never enter the table, and a faulted stage stops learning
    assign wr_en      = btb_upd && (btb_target[1:0] == 2'b00) && (state != FAULT);
    assign hit        = btb_valid[rd_idx] && (btb_tag[rd_idx] == pcf[ADDRESS_WIDTH-1:IDX_W+2]);
    assign hit_target = btb_tgt[rd_idx];
    assign unused_btb_bits = ^btb_pc[1:0];

    always_ff @(posedge clk) begin
        if (rst)
            btb_valid <= '0;
        else if (wr_en)
            btb_valid[wr_idx] <= 1'b1;
    end

    // lookup is combinational on the current contents, so a same-cycle write is seen next cycle
    always_ff @(posedge clk) begin
        if (wr_en) begin
            btb_tag[wr_idx] <= btb_pc[ADDRESS_WIDTH-1:IDX_W+2];
            btb_tgt[wr_idx] <= btb_target;
        end
    end
`else
    logic unused_btb;
    assign unused_btb = ^{btb_upd, btb_pc, btb_target, BTB_ENTRIES[0]};
    assign hit        = 1'b0;
    assign hit_target = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BOOT;
            pcf   <= RESET_PC;
        end else begin
            state <= state_next;
            pcf   <= pc_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pcf;
        case (state)
            BOOT: state_next = RUN;
            RUN: begin
                // a redirect flushes, so it beats a stall
                if (pcsrce) begin
                    if (pctargete[1:0] != 2'b00)
                        state_next = FAULT;
                    else
                        pc_next = pctargete;
                end else if (stallf) begin
                    pc_next = pcf;
                end else if (hit) begin
                    pc_next = hit_target;
                end else begin
                    pc_next = pcplus4f;
                end
            end
            FAULT:   state_next = FAULT;
            default: state_next = BOOT;
        endcase
    end

    assign validf     = (state == RUN);
    assign faultf     = (state == FAULT);
    assign predtakenf = (state == RUN) && hit;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: vector table fed through an expected-result queue,
// plus a second instance exercising PC wrap from the top of the address space.
module tb_fetch_stage;

`ifdef FETCH_BTB_EN
    localparam bit BTB_ON = 1'b1;
`else
    localparam bit BTB_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, stallf, pcsrce, btb_upd;
    logic [31:0] pctargete, btb_pc, btb_target;
    logic [31:0] pcf, pcplus4f, pcf2, pcplus4f2;
    logic        validf, predtakenf, faultf, validf2, predtakenf2, faultf2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_stage #(.ADDRESS_WIDTH(32), .RESET_PC(32'h0), .BTB_ENTRIES(4)) dut (
        .clk(clk), .rst(rst), .stallf(stallf), .pcsrce(pcsrce), .pctargete(pctargete),
        .btb_upd(btb_upd), .btb_pc(btb_pc), .btb_target(btb_target),
        .pcf(pcf), .pcplus4f(pcplus4f), .validf(validf), .predtakenf(predtakenf), .faultf(faultf));

    fetch_stage #(.ADDRESS_WIDTH(32), .RESET_PC(32'hFFFF_FFFC), .BTB_ENTRIES(4)) dut_wrap (
        .clk(clk), .rst(rst), .stallf(stallf), .pcsrce(pcsrce), .pctargete(pctargete),
        .btb_upd(btb_upd), .btb_pc(btb_pc), .btb_target(btb_target),
        .pcf(pcf2), .pcplus4f(pcplus4f2), .validf(validf2), .predtakenf(predtakenf2), .faultf(faultf2));

    typedef struct {
        string       name;
        logic        rst, stall, src, upd;
        logic [31:0] tgt, bpc, btgt;
        logic [31:0] epc;
        logic        ev, ef, ep;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    function automatic vec_t mk(string n, logic r, logic s, logic p, logic [31:0] t,
                                logic u, logic [31:0] bp, logic [31:0] bt,
                                logic [31:0] epc, logic ev, logic ef, logic ep);
        vec_t v;
        v.name = n; v.rst = r; v.stall = s; v.src = p; v.tgt = t;
        v.upd = u; v.bpc = bp; v.btgt = bt;
        v.epc = epc; v.ev = ev; v.ef = ef; v.ep = ep;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // drive one vector, queue its expectation, clock, then retire it against the DUT
    task automatic step(vec_t v);
        vec_t e;
        rst = v.rst; stallf = v.stall; pcsrce = v.src; pctargete = v.tgt;
        btb_upd = v.upd; btb_pc = v.bpc; btb_target = v.btgt;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.name, " pcf"},      pcf,               e.epc);
        chk({e.name, " pcplus4f"}, pcplus4f,          e.epc + 32'd4);
        chk({e.name, " validf"},   32'(validf),       32'(e.ev));
        chk({e.name, " faultf"},   32'(faultf),       32'(e.ef));
        chk({e.name, " predtaken"},32'(predtakenf),   32'(e.ep));
    endtask

    initial begin
        rst = 1'b1; stallf = 1'b0; pcsrce = 1'b0; pctargete = '0;
        btb_upd = 1'b0; btb_pc = '0; btb_target = '0;
        @(posedge clk); #1;

        // reset, boot cycle, and the wrap instance alongside
        step(mk("rst0", 1,0,0,0, 0,0,0, 32'h0, 0,0,0));
        step(mk("rst1", 1,0,0,0, 0,0,0, 32'h0, 0,0,0));
        chk("wrap reset pcf",      pcf2,      32'hFFFF_FFFC);
        chk("wrap reset pcplus4f", pcplus4f2, 32'h0);
        chk("wrap reset validf",   32'(validf2), 32'h0);
        step(mk("boot", 0,0,0,0, 0,0,0, 32'h0, 1,0,0));
        chk("wrap run pcf",    pcf2, 32'hFFFF_FFFC);
        chk("wrap run validf", 32'(validf2), 32'h1);
        step(mk("seq4", 0,0,0,0, 0,0,0, 32'h4, 1,0,0));
        chk("wrap next pcf", pcf2, 32'h0);
        chk("wrap next pcplus4f", pcplus4f2, 32'h4);

        tbl.push_back(mk("seq8",     0,0,0,32'h0,   0,0,0, 32'h8,  1,0,0));
        tbl.push_back(mk("stall1",   0,1,0,32'h0,   0,0,0, 32'h8,  1,0,0));
        tbl.push_back(mk("stall2",   0,1,0,32'h0,   0,0,0, 32'h8,  1,0,0));
        tbl.push_back(mk("stall3",   0,1,0,32'h0,   0,0,0, 32'h8,  1,0,0));
        tbl.push_back(mk("unstall",  0,0,0,32'h0,   0,0,0, 32'hC,  1,0,0));
        tbl.push_back(mk("redir_st", 0,1,1,32'h40,  0,0,0, 32'h40, 1,0,0));
        tbl.push_back(mk("post_red", 0,0,0,32'h0,   0,0,0, 32'h44, 1,0,0));
        tbl.push_back(mk("misalign", 0,0,1,32'h42,  0,0,0, 32'h44, 0,1,0));
        tbl.push_back(mk("flt_redir",0,0,1,32'h100, 0,0,0, 32'h44, 0,1,0));
        tbl.push_back(mk("flt_stall",0,1,0,32'h0,   0,0,0, 32'h44, 0,1,0));
        tbl.push_back(mk("flt_upd",  0,0,0,32'h0,   1,32'h44,32'h200, 32'h44, 0,1,0));
        tbl.push_back(mk("flt_rst",  1,0,0,32'h0,   0,0,0, 32'h0,  0,0,0));
        tbl.push_back(mk("reboot",   0,0,0,32'h0,   0,0,0, 32'h0,  1,0,0));
        tbl.push_back(mk("btb_wr",   0,0,0,32'h0,   1,32'h10,32'h80, 32'h4, 1,0,0));
        tbl.push_back(mk("btb_bad",  0,0,0,32'h0,   1,32'h24,32'h82, 32'h8, 1,0,0));
        tbl.push_back(mk("seqC",     0,0,0,32'h0,   0,0,0, 32'hC,  1,0,0));
        tbl.push_back(mk("at10",     0,0,0,32'h0,   0,0,0, 32'h10, 1,0,BTB_ON));
        tbl.push_back(mk("after10",  0,0,0,32'h0,   0,0,0, BTB_ON ? 32'h80 : 32'h14, 1,0,0));
        tbl.push_back(mk("to24",     0,0,1,32'h24,  0,0,0, 32'h24, 1,0,0));
        tbl.push_back(mk("after24",  0,0,0,32'h0,   0,0,0, 32'h28, 1,0,0));

        foreach (tbl[i]) step(tbl[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
